// File: rtl/chacha20_poly1305_bus_pkg.sv
// Shared constants and state encoding for the ChaCha20-Poly1305 bus master.
// Holds the responder register map, the CTRL/STATUS bit positions and the master FSM states.
package chacha20_poly1305_bus_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h08;
  localparam logic [7:0] ADDR_STATUS = 8'h09;
  localparam logic [7:0] ADDR_MODE   = 8'h0A;
  localparam logic [7:0] ADDR_KEY0   = 8'h10;
  localparam logic [7:0] ADDR_NONCE0 = 8'h20;
  localparam logic [7:0] ADDR_DATA   = 8'h30;
  localparam logic [7:0] ADDR_TAG    = 8'h40;

  localparam int CTRL_INIT = 0;
  localparam int CTRL_NEXT = 1;
  localparam int CTRL_DONE = 2;

  localparam int ST_READY  = 0;
  localparam int ST_VALID  = 1;
  localparam int ST_TAG_OK = 2;

  localparam logic [2:0] MASK_READY = 3'b001 << ST_READY;
  localparam logic [2:0] MASK_VALID = 3'b001 << ST_VALID;

  typedef enum logic [4:0] {
    S_IDLE, S_WR_KEY, S_WR_NONCE, S_WR_MODE, S_INIT, S_CLR, S_POLL,
    S_BLK_WAIT, S_WR_DATA, S_NEXT, S_RD_DATA, S_RD_DATA_W, S_OUT_BLK,
    S_FIN, S_RD_TAG, S_RD_TAG_W, S_RD_ST, S_RD_ST_W, S_OUT_TAG, S_ABORT
  } state_t;

endpackage

// File: rtl/chacha20_poly1305_poll_unit.sv
// STATUS polling loop: alternates a read cycle with a check cycle until a masked
// status bit is seen or POLL_LIMIT polls have failed.
module chacha20_poly1305_poll_unit #(
  parameter int POLL_LIMIT = 1024,
  parameter int PCNT_W     = 11
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [2:0] mask,
  input  logic [2:0] read_data,
  output logic       rd,
  output logic       hit,
  output logic       timeout
);

  typedef enum logic [1:0] {P_IDLE, P_ISSUE, P_CHECK} phase_t;

  phase_t            phase;
  logic [PCNT_W-1:0] cnt;
  logic              match;
  logic              last_poll;

  // read_data is registered by the responder, so it is only meaningful in the check cycle
  assign match     = |(read_data & mask);
  assign last_poll = (cnt == PCNT_W'(POLL_LIMIT - 1));
  assign rd        = (phase == P_ISSUE);
  assign hit       = (phase == P_CHECK) && match;
  assign timeout   = (phase == P_CHECK) && !match && last_poll;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase <= P_IDLE;
      cnt   <= '0;
    end else if (start) begin
      phase <= P_ISSUE;
      cnt   <= '0;
    end else begin
      case (phase)
        P_ISSUE: phase <= P_CHECK;
        P_CHECK: begin
          if (match || last_poll) begin
            phase <= P_IDLE;
          end else begin
            cnt   <= cnt + 1'b1;
            phase <= P_ISSUE;
          end
        end
        default: phase <= P_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/chacha20_poly1305_bus_master.sv
// Bus initiator that sequences the ChaCha20-Poly1305 register responder for a
// streaming client: key/nonce/mode setup, per-block write/poll/read, then tag readout.
module chacha20_poly1305_bus_master
  import chacha20_poly1305_bus_pkg::*;
#(
  parameter int POLL_LIMIT = 1024,
  parameter int PCNT_W     = 11
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [255:0] job_key,
  input  logic [95:0]  job_nonce,
  input  logic         job_encdec,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_data,
  output logic         tag_valid,
  input  logic         tag_ready,
  output logic [127:0] tag,
  output logic         tag_ok,
  output logic         err,
  output logic         cs,
  output logic         we,
  output logic [7:0]   address,
  output logic [511:0] write_data,
  input  logic [511:0] read_data
);

  state_t         state, state_nx, ret_state;
  logic [255:0]   key_q;
  logic [95:0]    nonce_q;
  logic           encdec_q;
  logic [511:0]   blk_q;
  logic           last_q;
  logic [2:0]     idx;
  logic [2:0]     mask_q;
  logic           poll_start, poll_rd, poll_hit, poll_timeout;

  chacha20_poly1305_poll_unit #(
    .POLL_LIMIT(POLL_LIMIT),
    .PCNT_W    (PCNT_W)
  ) u_poll (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (poll_start),
    .mask     (mask_q),
    .read_data(read_data[2:0]),
    .rd       (poll_rd),
    .hit      (poll_hit),
    .timeout  (poll_timeout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      if (job_valid) state_nx = S_WR_KEY;
      S_WR_KEY:    if (idx == 3'd7) state_nx = S_WR_NONCE;
      S_WR_NONCE:  if (idx == 3'd2) state_nx = S_WR_MODE;
      S_WR_MODE:   state_nx = S_INIT;
      S_INIT, S_NEXT, S_FIN: state_nx = S_CLR;
      S_CLR:       state_nx = S_POLL;
      S_POLL: begin
        if (poll_timeout)  state_nx = S_ABORT;
        else if (poll_hit) state_nx = ret_state;
      end
      S_BLK_WAIT:  if (blk_valid) state_nx = S_WR_DATA;
      S_WR_DATA:   state_nx = S_NEXT;
      S_RD_DATA:   state_nx = S_RD_DATA_W;
      S_RD_DATA_W: state_nx = S_OUT_BLK;
      S_OUT_BLK:   if (out_ready) state_nx = last_q ? S_FIN : S_BLK_WAIT;
      S_RD_TAG:    state_nx = S_RD_TAG_W;
      S_RD_TAG_W:  state_nx = S_RD_ST;
      S_RD_ST:     state_nx = S_RD_ST_W;
      S_RD_ST_W:   state_nx = S_OUT_TAG;
      S_OUT_TAG:   if (tag_ready) state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  // Bus outputs decode straight from state so reset drops cs without waiting for a clock
  always_comb begin
    cs         = 1'b0;
    we         = 1'b0;
    address    = '0;
    write_data = '0;
    poll_start = 1'b0;
    err        = 1'b0;
    case (state)
      S_WR_KEY: begin
        cs = 1'b1; we = 1'b1;
        address          = ADDR_KEY0 + {5'b0, idx};
        write_data[31:0] = key_q[255:224];
      end
      S_WR_NONCE: begin
        cs = 1'b1; we = 1'b1;
        address          = ADDR_NONCE0 + {5'b0, idx};
        write_data[31:0] = nonce_q[31:0];
      end
      S_WR_MODE: begin
        cs = 1'b1; we = 1'b1;
        address       = ADDR_MODE;
        write_data[0] = encdec_q;
      end
      S_INIT: begin
        cs = 1'b1; we = 1'b1; address = ADDR_CTRL;
        write_data[CTRL_INIT] = 1'b1;
      end
      S_NEXT: begin
        cs = 1'b1; we = 1'b1; address = ADDR_CTRL;
        write_data[CTRL_NEXT] = 1'b1;
      end
      S_FIN: begin
        cs = 1'b1; we = 1'b1; address = ADDR_CTRL;
        write_data[CTRL_DONE] = 1'b1;
      end
      S_CLR: begin
        cs = 1'b1; we = 1'b1; address = ADDR_CTRL;
        poll_start = 1'b1;
      end
      S_ABORT: begin
        cs = 1'b1; we = 1'b1; address = ADDR_CTRL;
        err = 1'b1;
      end
      S_POLL: begin
        cs      = poll_rd;
        address = poll_rd ? ADDR_STATUS : 8'h00;
      end
      S_WR_DATA: begin
        cs = 1'b1; we = 1'b1; address = ADDR_DATA;
        write_data = blk_q;
      end
      S_RD_DATA: begin cs = 1'b1; address = ADDR_DATA;   end
      S_RD_TAG:  begin cs = 1'b1; address = ADDR_TAG;    end
      S_RD_ST:   begin cs = 1'b1; address = ADDR_STATUS; end
      default: ;
    endcase
  end

  assign job_ready = (state == S_IDLE);
  assign blk_ready = (state == S_BLK_WAIT);
  assign out_valid = (state == S_OUT_BLK);
  assign tag_valid = (state == S_OUT_TAG);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q     <= '0;
      nonce_q   <= '0;
      encdec_q  <= 1'b0;
      blk_q     <= '0;
      last_q    <= 1'b0;
      idx       <= '0;
      mask_q    <= '0;
      ret_state <= S_IDLE;
      out_data  <= '0;
      tag       <= '0;
      tag_ok    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (job_valid) begin
          key_q    <= job_key;
          nonce_q  <= job_nonce;
          encdec_q <= job_encdec;
          idx      <= '0;
        end
        // key goes out most-significant word first, nonce least-significant first
        S_WR_KEY: begin
          key_q <= {key_q[223:0], 32'h0};
          idx   <= (idx == 3'd7) ? 3'd0 : idx + 3'd1;
        end
        S_WR_NONCE: begin
          nonce_q <= {32'h0, nonce_q[95:32]};
          idx     <= (idx == 3'd2) ? 3'd0 : idx + 3'd1;
        end
        S_INIT: begin ret_state <= S_BLK_WAIT; mask_q <= MASK_READY; end
        S_NEXT: begin ret_state <= S_RD_DATA;  mask_q <= MASK_VALID; end
        S_FIN:  begin ret_state <= S_RD_TAG;   mask_q <= MASK_READY; end
        S_BLK_WAIT: if (blk_valid) begin
          blk_q  <= blk_data;
          last_q <= blk_last;
        end
        S_RD_DATA_W: out_data <= read_data;
        S_RD_TAG_W:  tag      <= read_data[127:0];
        S_RD_ST_W:   tag_ok   <= read_data[ST_TAG_OK];
        S_ABORT: begin
          out_data <= '0;
          tag      <= '0;
          tag_ok   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha20_poly1305_bus_master.sv
// Directed bench for the ChaCha20-Poly1305 bus master with a behavioural register responder.
module tb_chacha20_poly1305_bus_master;

  localparam logic [255:0] KEY   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [95:0]  NONCE = 96'h000000000000004a00000009;
  localparam logic [511:0] KS    = {16{32'h0badf00d}};
  localparam logic [127:0] TAG1  = 128'h1ae10b594f09e26a7e902ecbd0600691;
  localparam logic [127:0] TAG2  = 128'h0123456789abcdeffedcba9876543210;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         job_valid = 1'b0, job_ready, job_encdec = 1'b0;
  logic [255:0] job_key = '0;
  logic [95:0]  job_nonce = '0;
  logic         blk_valid = 1'b0, blk_ready, blk_last = 1'b0;
  logic [511:0] blk_data = '0;
  logic         out_valid, out_ready = 1'b1;
  logic [511:0] out_data;
  logic         tag_valid, tag_ready = 1'b1, tag_ok, err;
  logic [127:0] tag;
  logic         cs, we;
  logic [7:0]   address;
  logic [511:0] write_data;
  logic [511:0] read_data = '0;

  int checks = 0;
  int failures = 0;

  chacha20_poly1305_bus_master #(.POLL_LIMIT(8), .PCNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_key(job_key),
    .job_nonce(job_nonce), .job_encdec(job_encdec),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_last(blk_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .tag_valid(tag_valid), .tag_ready(tag_ready), .tag(tag), .tag_ok(tag_ok),
    .err(err), .cs(cs), .we(we), .address(address),
    .write_data(write_data), .read_data(read_data)
  );

  always #5 clk = ~clk;

  // Responder model: STATUS reports the pending bit on the cfg_polls-th read after a CTRL set-write
  int           cfg_polls = 1;
  logic         cfg_tag_ok = 1'b1;
  logic [127:0] cfg_tag = TAG1;
  int           st_reads = 0;
  logic [1:0]   st_mask = 2'b01;
  logic [511:0] data_in = '0;
  int           cyc = 0;
  logic [7:0]   log_addr[$];
  logic         log_we[$];
  logic [31:0]  log_data[$];
  int           log_cyc[$];

  always @(posedge clk) begin : responder
    int n;
    cyc <= cyc + 1;
    if (cs) begin
      log_addr.push_back(address);
      log_we.push_back(we);
      log_data.push_back(write_data[31:0]);
      log_cyc.push_back(cyc);
      if (we) begin
        if (address == 8'h08 && write_data[2:0] != 3'b000) begin
          st_reads <= 0;
          st_mask  <= write_data[1] ? 2'b10 : 2'b01;
        end
        if (address == 8'h30) data_in <= write_data;
      end else begin
        n = st_reads + 1;
        case (address)
          8'h09: begin
            st_reads  <= n;
            read_data <= {509'b0, cfg_tag_ok, (cfg_polls != 0 && n >= cfg_polls) ? st_mask : 2'b00};
          end
          8'h30:   read_data <= data_in ^ KS;
          8'h40:   read_data <= {384'b0, cfg_tag};
          default: read_data <= '0;
        endcase
      end
    end
  end

  function automatic logic sig(input int sel);
    case (sel)
      0:       return blk_ready;
      1:       return out_valid;
      2:       return tag_valid;
      3:       return err;
      default: return job_ready;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (sig(sel)) begin ok = 1'b1; break; end
    end
  endtask

  task automatic start_job(input logic [255:0] k, input logic [95:0] nn, input logic ed);
    @(negedge clk);
    job_key = k; job_nonce = nn; job_encdec = ed; job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic send_block(input logic [511:0] d, input logic l, output bit ok);
    wait_for(0, 200, ok);
    if (ok) begin
      blk_data = d; blk_last = l; blk_valid = 1'b1;
      @(negedge clk);
      blk_valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (job_ready !== 1'b1) begin
      failures++; $display("FAIL reset_job_ready got=%b exp=1", job_ready);
    end
    checks++;
    if ({cs, we, address, write_data, out_valid, tag_valid, err, blk_ready, out_data, tag, tag_ok} !== '0) begin
      failures++; $display("FAIL reset_outputs cs=%b we=%b addr=%h ov=%b tv=%b err=%b br=%b exp=all 0",
                           cs, we, address, out_valid, tag_valid, err, blk_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_job_setup;
    int b;
    bit ok;
    logic [7:0]  ea;
    logic [31:0] ed;
    logic [31:0] nw [3];
    nw[0] = 32'h00000009; nw[1] = 32'h0000004a; nw[2] = 32'h00000000;
    cfg_polls = 3;
    b = log_addr.size();
    start_job(KEY, NONCE, 1'b1);
    wait_for(0, 200, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL setup_blk_ready got=0 exp=1 within 200 cycles"); end
    checks++;
    if (log_addr.size() < b + 17) begin
      failures++; $display("FAIL setup_log_len got=%0d exp>=17", log_addr.size() - b);
    end else begin
      for (int i = 0; i < 14; i++) begin
        if (i < 8) begin
          ea = 8'(8'h10 + i);
          ed = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        end else if (i < 11) begin
          ea = 8'(8'h20 + i - 8); ed = nw[i-8];
        end else if (i == 11) begin
          ea = 8'h0A; ed = 32'h1;
        end else begin
          ea = 8'h08; ed = (i == 12) ? 32'h1 : 32'h0;
        end
        checks++;
        if (log_we[b+i] !== 1'b1 || log_addr[b+i] !== ea || log_data[b+i] !== ed ||
            (i > 0 && log_cyc[b+i] !== log_cyc[b+i-1] + 1)) begin
          failures++;
          $display("FAIL setup_write[%0d] got we=%b addr=%h data=%h exp we=1 addr=%h data=%h consecutive",
                   i, log_we[b+i], log_addr[b+i], log_data[b+i], ea, ed);
        end
      end
      for (int i = 14; i < 17; i++) begin
        checks++;
        if (log_we[b+i] !== 1'b0 || log_addr[b+i] !== 8'h09) begin
          failures++; $display("FAIL setup_poll[%0d] got we=%b addr=%h exp we=0 addr=09", i, log_we[b+i], log_addr[b+i]);
        end
      end
    end
    checks++;
    if (st_reads !== 3) begin failures++; $display("FAIL setup_poll_count got=%0d exp=3", st_reads); end
  endtask

  task automatic test_single_block;
    int b;
    bit ok;
    logic [7:0] ea [12];
    logic       ew [12];
    logic [31:0] ed [12];
    ea = '{8'h30, 8'h08, 8'h08, 8'h09, 8'h09, 8'h30, 8'h08, 8'h08, 8'h09, 8'h09, 8'h40, 8'h09};
    ew = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    ed = '{32'ha5a5a5a5, 32'h2, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    cfg_polls = 2; cfg_tag = TAG1; cfg_tag_ok = 1'b1;
    b = log_addr.size();
    send_block({64{8'ha5}}, 1'b1, ok);
    wait_for(1, 200, ok);
    checks++;
    if (!ok || out_data !== {16{32'hae0855a8}}) begin
      failures++; $display("FAIL single_out_data got=%h exp=%h", out_data, {16{32'hae0855a8}});
    end
    checks++;
    if (tag_valid !== 1'b0) begin failures++; $display("FAIL single_exclusive got tag_valid=%b exp=0", tag_valid); end
    wait_for(2, 200, ok);
    checks++;
    if (!ok || tag !== TAG1 || tag_ok !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL single_tag got ok=%b tag=%h tag_ok=%b ov=%b exp tag=%h tag_ok=1 ov=0",
                           ok, tag, tag_ok, out_valid, TAG1);
    end
    @(negedge clk);
    checks++;
    if (job_ready !== 1'b1 || tag_valid !== 1'b0) begin
      failures++; $display("FAIL single_done got job_ready=%b tag_valid=%b exp 1/0", job_ready, tag_valid);
    end
    checks++;
    if (log_addr.size() < b + 12) begin
      failures++; $display("FAIL single_log_len got=%0d exp=12", log_addr.size() - b);
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (log_addr[b+i] !== ea[i] || log_we[b+i] !== ew[i] || (ew[i] && log_data[b+i] !== ed[i])) begin
          failures++; $display("FAIL single_bus[%0d] got addr=%h we=%b data=%h exp addr=%h we=%b data=%h",
                               i, log_addr[b+i], log_we[b+i], log_data[b+i], ea[i], ew[i], ed[i]);
        end
      end
      checks++;
      if (log_cyc[b+4] !== log_cyc[b+3] + 2 || log_cyc[b+7] !== log_cyc[b+6] + 1) begin
        failures++; $display("FAIL single_spacing got poll_gap=%0d clr_gap=%0d exp 2/1",
                             log_cyc[b+4] - log_cyc[b+3], log_cyc[b+7] - log_cyc[b+6]);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    bit bad;
    logic [511:0] hold;
    cfg_polls = 1;
    start_job(KEY, NONCE, 1'b0);
    send_block({16{32'h11111111}}, 1'b0, ok);
    wait_for(1, 200, ok);
    checks++;
    if (!ok || out_data !== {16{32'h1abce11c}}) begin
      failures++; $display("FAIL b2b_blk1 got=%h exp=%h", out_data, {16{32'h1abce11c}});
    end
    send_block({16{32'h22222222}}, 1'b0, ok);
    out_ready = 1'b0;
    wait_for(1, 200, ok);
    checks++;
    if (!ok || out_data !== {16{32'h298fd22f}}) begin
      failures++; $display("FAIL b2b_blk2 got=%h exp=%h", out_data, {16{32'h298fd22f}});
    end
    hold = out_data;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (blk_ready || !out_valid || tag_valid || out_data !== hold) bad = 1'b1;
    end
    checks++;
    if (bad) begin failures++; $display("FAIL b2b_stall got blk_ready/out_valid disturbed exp blk_ready=0 out_valid=1"); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_taken got out_valid=%b exp=0", out_valid); end
    send_block({16{32'h33333333}}, 1'b1, ok);
    wait_for(1, 200, ok);
    checks++;
    if (!ok || out_data !== {16{32'h389ec33e}}) begin
      failures++; $display("FAIL b2b_blk3 got=%h exp=%h", out_data, {16{32'h389ec33e}});
    end
    wait_for(2, 200, ok);
    checks++;
    if (!ok || tag !== TAG1) begin failures++; $display("FAIL b2b_tag got=%h exp=%h", tag, TAG1); end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    bit ok;
    cfg_polls = 0;
    start_job(KEY, NONCE, 1'b1);
    wait_for(3, 300, ok);
    checks++;
    if (!ok || st_reads !== 8) begin
      failures++; $display("FAIL timeout_polls got err=%b polls=%0d exp err=1 polls=8", ok, st_reads);
    end
    checks++;
    if (cs !== 1'b1 || we !== 1'b1 || address !== 8'h08 || write_data !== '0 || out_valid || tag_valid) begin
      failures++; $display("FAIL timeout_ctrl_clear got cs=%b we=%b addr=%h ov=%b tv=%b exp ctrl write 0",
                           cs, we, address, out_valid, tag_valid);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || job_ready !== 1'b1) begin
      failures++; $display("FAIL timeout_recover got err=%b job_ready=%b exp 0/1", err, job_ready);
    end
    cfg_polls = 1;
  endtask

  task automatic test_reset_midway;
    bit ok;
    int b;
    start_job(KEY, NONCE, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (cs && address == 8'h20) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL midreset_reach_nonce got=0 exp=1"); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (cs !== 1'b0 || we !== 1'b0 || address !== 8'h00 || job_ready !== 1'b1) begin
      failures++; $display("FAIL midreset_async got cs=%b we=%b addr=%h job_ready=%b exp 0/0/00/1",
                           cs, we, address, job_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    b = log_addr.size();
    start_job(KEY, NONCE, 1'b1);
    send_block({64{8'ha5}}, 1'b1, ok);
    wait_for(1, 200, ok);
    checks++;
    if (!ok || out_data !== {16{32'hae0855a8}}) begin
      failures++; $display("FAIL midreset_out got=%h exp=%h", out_data, {16{32'hae0855a8}});
    end
    checks++;
    if (log_addr[b] !== 8'h10 || log_data[b] !== 32'h00010203) begin
      failures++; $display("FAIL midreset_restart got addr=%h data=%h exp 10/00010203", log_addr[b], log_data[b]);
    end
    wait_for(2, 200, ok);
    checks++;
    if (!ok || tag !== TAG1 || tag_ok !== 1'b1) begin
      failures++; $display("FAIL midreset_tag got=%h ok=%b exp=%h ok=1", tag, tag_ok, TAG1);
    end
    @(negedge clk);
  endtask

  task automatic test_tag_fail;
    bit ok;
    bit bad;
    cfg_tag_ok = 1'b0; cfg_tag = TAG2; tag_ready = 1'b0;
    start_job(KEY, NONCE, 1'b0);
    send_block({16{32'h11111111}}, 1'b1, ok);
    wait_for(2, 300, ok);
    checks++;
    if (!ok || tag_ok !== 1'b0 || tag !== TAG2) begin
      failures++; $display("FAIL tagfail_value got tag=%h tag_ok=%b exp tag=%h tag_ok=0", tag, tag_ok, TAG2);
    end
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!tag_valid || out_valid || tag !== TAG2 || job_ready) bad = 1'b1;
    end
    checks++;
    if (bad) begin failures++; $display("FAIL tagfail_hold got tag_valid dropped exp held until tag_ready"); end
    tag_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (tag_valid !== 1'b0 || job_ready !== 1'b1) begin
      failures++; $display("FAIL tagfail_release got tag_valid=%b job_ready=%b exp 0/1", tag_valid, job_ready);
    end
    cfg_tag_ok = 1'b1; cfg_tag = TAG1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_job_setup;
    test_single_block;
    test_back_to_back;
    test_timeout;
    test_reset_midway;
    test_tag_fail;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
